// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbitration onto one single-port memory; ack one cycle after the grant cycle.
// Requesters hold req until ack; data wins ties unless fetch has starved. Grant counters under MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic [15:0]   if_grant_cnt,
  output logic [15:0]   d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state, next_state;
  logic [3:0]      starve_cnt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;
  logic            if_ack_q, d_ack_q, ack_we_q;
  logic            elig_if, elig_d;

  // A port granted this cycle acks next cycle, so it cannot be granted again then.
  assign elig_if = if_req && (state != GNT_IF);
  assign elig_d  = d_req  && (state != GNT_D);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (elig_if && elig_d)
      next_state = (starve_cnt == STARVE_LIM) ? GNT_IF : GNT_D;
    else if (elig_if)
      next_state = GNT_IF;
    else if (elig_d)
      next_state = GNT_D;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      ack_we_q   <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      case (next_state)
        GNT_IF: begin
          addr_q  <= if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
        GNT_D: begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end
        default: begin
          addr_q  <= '0;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      endcase
      if_ack_q <= (state == GNT_IF);
      d_ack_q  <= (state == GNT_D);
      ack_we_q <= (state == GNT_D) && we_q;
      if (!if_req || state == GNT_IF)
        starve_cnt <= 4'd0;
      else if (starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_en    = (state != IDLE);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = if_ack_q;
    d_ack     = d_ack_q;
    if_rdata  = if_ack_q ? mem_rdata : '0;
    d_rdata   = (d_ack_q && !ack_we_q) ? mem_rdata : '0;
    stall_if  = rst && if_req && !if_ack_q;
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] if_cnt_q, d_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_cnt_q <= 16'd0;
      d_cnt_q  <= 16'd0;
    end else begin
      if (next_state == GNT_IF && if_cnt_q != 16'hFFFF) if_cnt_q <= if_cnt_q + 16'd1;
      if (next_state == GNT_D  && d_cnt_q  != 16'hFFFF) d_cnt_q  <= d_cnt_q  + 16'd1;
    end
  end

  assign if_grant_cnt = if_cnt_q;
  assign d_grant_cnt  = d_cnt_q;
`else
  assign if_grant_cnt = 16'd0;
  assign d_grant_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized run vs reference model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic [15:0]   if_grant_cnt, d_grant_cnt;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if),
    .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_init(input logic [7:0] a);
    if (a == 8'h04) return 32'h00500093;
    return {a ^ 8'hC3, ~a, a, 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behind the arbiter: one access per cycle, read data one cycle after mem_en.
  logic [31:0] sram [256];
  logic        sram_pend = 1'b0;
  logic [7:0]  sram_addr = 8'h00;

  task automatic sram_cycle();
    if (sram_pend) mem_rdata = sram[sram_addr];
    else           mem_rdata = $urandom;
    if (mem_en) begin
      if (mem_we) sram[mem_addr] = mem_wdata;
      sram_pend = 1'b1;
      sram_addr = mem_addr;
    end else begin
      sram_pend = 1'b0;
    end
  endtask

  // Reference model: who owns the memory this cycle, what it returns next cycle.
  logic [31:0] ref_mem [256];
  int          owner = 0;       // 0 none, 1 fetch, 2 data
  int          starve = 0;
  logic        own_we = 1'b0;
  logic [31:0] pend_rd = '0;
  logic        e_iack, e_dack, e_en, e_we;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_ird, e_drd;
  int          e_ic = 0, e_dc = 0;

  task automatic init_mems();
    for (int i = 0; i < 256; i++) begin
      sram[i]    = sram_init(8'(i));
      ref_mem[i] = sram_init(8'(i));
    end
  endtask

  task automatic model_edge();
    int g;
    bit fetch_ok, data_ok;
    if (!rst) begin
      owner = 0; starve = 0; own_we = 1'b0;
      e_iack = 0; e_dack = 0; e_en = 0; e_we = 0; e_addr = '0;
      e_wdata = '0; e_ird = '0; e_drd = '0; e_ic = 0; e_dc = 0;
    end else begin
      e_iack = (owner == 1);
      e_dack = (owner == 2);
      e_ird  = (owner == 1) ? pend_rd : 32'h0;
      e_drd  = (owner == 2 && !own_we) ? pend_rd : 32'h0;
      fetch_ok = if_req && owner != 1;
      data_ok  = d_req && owner != 2;
      if (fetch_ok && data_ok) g = (starve == SMAX) ? 1 : 2;
      else if (fetch_ok)       g = 1;
      else if (data_ok)        g = 2;
      else                     g = 0;
      starve = (!if_req || owner == 1) ? 0 : ((starve < SMAX) ? starve + 1 : SMAX);
      e_en = (g != 0); e_we = 0; e_addr = '0; e_wdata = '0;
      if (g == 1) begin
        e_addr = if_addr;
        pend_rd = ref_mem[if_addr];
        if (e_ic < 65535) e_ic++;
      end else if (g == 2) begin
        e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; own_we = d_we;
        if (d_we) ref_mem[d_addr] = d_wdata;
        pend_rd = ref_mem[d_addr];
        if (e_dc < 65535) e_dc++;
      end
      owner = g;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    sram_cycle();
    #1;
  endtask

  task automatic compare_model();
    int xi, xd;
`ifdef MEM_ARB_STATS_EN
    xi = e_ic; xd = e_dc;
`else
    xi = 0; xd = 0;
`endif
    chk("rnd_if_ack", if_ack, e_iack);
    chk("rnd_d_ack", d_ack, e_dack);
    chk("rnd_if_rdata", if_rdata, e_ird);
    chk("rnd_d_rdata", d_rdata, e_drd);
    chk("rnd_mem_en", mem_en, e_en);
    chk("rnd_mem_we", mem_we, e_we);
    chk("rnd_mem_addr", mem_addr, e_addr);
    if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
    chk("rnd_stall_if", stall_if, rst && if_req && !e_iack);
    chk("rnd_if_cnt", if_grant_cnt, xi);
    chk("rnd_d_cnt", d_grant_cnt, xd);
    chk("rnd_no_dual_ack", if_ack && d_ack, 0);
  endtask

  typedef struct {
    logic rs, ir; logic [7:0] ia;
    logic dr, dw; logic [7:0] da; logic [31:0] dwd;
    logic x_en, x_we; logic [7:0] x_addr;
    logic x_iack, x_dack; logic [31:0] x_ird, x_drd; logic x_stall;
  } vec_t;

  function automatic vec_t mk(input logic rs, ir, input logic [7:0] ia, input logic dr, dw,
                              input logic [7:0] da, input logic [31:0] dwd,
                              input logic x_en, x_we, input logic [7:0] x_addr,
                              input logic x_iack, x_dack, input logic [31:0] x_ird, x_drd,
                              input logic x_stall);
    vec_t v;
    v.rs = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.x_en = x_en; v.x_we = x_we; v.x_addr = x_addr; v.x_iack = x_iack; v.x_dack = x_dack;
    v.x_ird = x_ird; v.x_drd = x_drd; v.x_stall = x_stall;
    return v;
  endfunction

  vec_t tbl [15];
  logic found, acked;

  initial begin
    rst = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    init_mems();

    // inputs for the cycle | outputs after the next edge
    tbl[0]  = mk(0,0,8'h00,0,0,8'h00,32'h0,        0,0,8'h00,0,0,32'h0,32'h0,0);
    tbl[1]  = mk(1,1,8'h04,0,0,8'h00,32'h0,        1,0,8'h04,0,0,32'h0,32'h0,1);
    tbl[2]  = mk(1,1,8'h04,0,0,8'h00,32'h0,        0,0,8'h00,1,0,32'h00500093,32'h0,0);
    tbl[3]  = mk(1,0,8'h00,0,0,8'h00,32'h0,        0,0,8'h00,0,0,32'h0,32'h0,0);
    tbl[4]  = mk(1,1,8'h08,1,1,8'h10,32'hDEADBEEF, 1,1,8'h10,0,0,32'h0,32'h0,1);
    tbl[5]  = mk(1,1,8'h08,1,1,8'h10,32'hDEADBEEF, 1,0,8'h08,0,1,32'h0,32'h0,1);
    tbl[6]  = mk(1,1,8'h08,0,0,8'h00,32'h0,        0,0,8'h00,1,0,sram_init(8'h08),32'h0,0);
    tbl[7]  = mk(1,0,8'h00,1,0,8'h10,32'h0,        1,0,8'h10,0,0,32'h0,32'h0,0);
    tbl[8]  = mk(1,0,8'h00,1,0,8'h10,32'h0,        0,0,8'h00,0,1,32'h0,32'hDEADBEEF,0);
    tbl[9]  = mk(1,0,8'h00,1,1,8'h20,32'h12345678, 1,1,8'h20,0,0,32'h0,32'h0,0);
    tbl[10] = mk(0,0,8'h00,1,1,8'h20,32'h12345678, 0,0,8'h00,0,0,32'h0,32'h0,0);
    tbl[11] = mk(1,0,8'h00,0,0,8'h00,32'h0,        0,0,8'h00,0,0,32'h0,32'h0,0);
    tbl[12] = mk(1,1,8'h44,1,0,8'h30,32'h0,        1,0,8'h30,0,0,32'h0,32'h0,1);
    tbl[13] = mk(1,0,8'h44,1,0,8'h30,32'h0,        0,0,8'h00,0,1,32'h0,sram_init(8'h30),0);
    tbl[14] = mk(1,0,8'h00,0,0,8'h00,32'h0,        0,0,8'h00,0,0,32'h0,32'h0,0);

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rs; if_req = tbl[i].ir; if_addr = tbl[i].ia;
      d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
      step();
      chk($sformatf("vec%0d_mem_en", i), mem_en, tbl[i].x_en);
      chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].x_we);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].x_addr);
      chk($sformatf("vec%0d_if_ack", i), if_ack, tbl[i].x_iack);
      chk($sformatf("vec%0d_d_ack", i), d_ack, tbl[i].x_dack);
      chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].x_ird);
      chk($sformatf("vec%0d_d_rdata", i), d_rdata, tbl[i].x_drd);
      chk($sformatf("vec%0d_stall_if", i), stall_if, tbl[i].x_stall);
      if (i == 0) begin
        chk("reset_if_cnt", if_grant_cnt, 0);
        chk("reset_d_cnt", d_grant_cnt, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
      end
    end

    // Data held continuously: fetch must still get the memory within 4 cycles.
    rst = 0; if_req = 0; d_req = 0; step();
    rst = 1; d_req = 1; d_we = 0; d_addr = 8'h02; if_req = 1; if_addr = 8'h55;
    found = 0;
    for (int c = 0; c < 4 && !found; c++) begin
      step();
      if (mem_en && !mem_we && mem_addr == 8'h55) found = 1;
    end
    chk("starve_fetch_grant", found, 1);

    // Grant counters: 5 fetch grants then 2 data grants from reset.
    rst = 0; if_req = 0; d_req = 0; step();
    rst = 1;
    for (int k = 0; k < 5; k++) begin
      if_req = 1; if_addr = 8'(k + 1); acked = 0;
      for (int c = 0; c < 6 && !acked; c++) begin step(); acked = if_ack; end
      chk("stats_if_ack", acked, 1);
      if_req = 0;
    end
    for (int k = 0; k < 2; k++) begin
      d_req = 1; d_we = 1; d_addr = 8'(k + 8'h40); d_wdata = $urandom; acked = 0;
      for (int c = 0; c < 6 && !acked; c++) begin step(); acked = d_ack; end
      chk("stats_d_ack", acked, 1);
      d_req = 0;
    end
    step();
`ifdef MEM_ARB_STATS_EN
    chk("stats_if_cnt", if_grant_cnt, 5);
    chk("stats_d_cnt", d_grant_cnt, 2);
`else
    chk("stats_if_cnt", if_grant_cnt, 0);
    chk("stats_d_cnt", d_grant_cnt, 0);
`endif

    // Randomized traffic against the reference model.
    rst = 0; if_req = 0; d_req = 0; step();
    init_mems();
    rst = 1;
    for (int n = 0; n < 2000; n++) begin
      step();
      compare_model();
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if (if_req && if_ack) if_req = 0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = 8'($urandom_range(0, 15));
      end
      if (d_req && d_ack) d_req = 0;
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 8'($urandom_range(0, 15)); d_wdata = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
